// File: rtl/gpio_mmio_pkg.sv
// rtl/gpio_mmio_pkg.sv - shared addresses and debouncer state type for the GPIO MMIO bridge
package gpio_mmio_pkg;

    localparam logic [31:0] DEF_OUT_ADDR    = 32'h1001_0024;
    localparam logic [31:0] DEF_IN_ADDR     = 32'h1001_0028;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001_002C;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } dbState_t;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - two-flop synchronizer plus whole-byte debouncer
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   raw     : asynchronous input pins
//   db      : debounced input byte
//   changed : high in the cycle whose rising edge loads a new db value
module gpio_debounce
    import gpio_mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw,
    output logic [7:0] db,
    output logic       changed
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

    logic [7:0] sync1;
    logic [7:0] inSync;
    logic [7:0] cnt;
    dbState_t   state;

    // Combinational so the flag in the top sets on the same edge that db loads.
    assign changed = (state == COUNTING) && (inSync != db) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 8'h00;
            inSync <= 8'h00;
            db     <= 8'h00;
            cnt    <= 8'h00;
            state  <= STABLE;
        end else begin
            sync1  <= raw;
            inSync <= sync1;
            case (state)
                STABLE: begin
                    if (inSync != db) begin
                        state <= COUNTING;
                        cnt   <= 8'd1;
                    end
                end
                COUNTING: begin
                    // A new differing value mid-count keeps counting: only
                    // agreement with db counts as a rejected glitch.
                    if (inSync == db) begin
                        state <= STABLE;
                        cnt   <= 8'h00;
                    end else if (cnt < CNT_MAX) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        db    <= inSync;
                        state <= STABLE;
                        cnt   <= 8'h00;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_mmio_bridge.sv
// rtl/gpio_mmio_bridge.sv - memory-mapped GPIO output, debounced input and change flag
//   clk, reset   : clock and asynchronous active-low reset
//   Address      : core data address
//   WriteData    : core store data
//   MemWrite     : core store strobe
//   MemReadData  : read data from memory, returned for non-GPIO addresses
//   gpio_in      : asynchronous input pins
//   ReadData     : combinational read data to the core
//   MemWriteOut  : store strobe to memory, suppressed for GPIO addresses
//   gpio_out     : registered output pins
//   change_irq   : level, set when the debounced input changes
module gpio_mmio_bridge
    import gpio_mmio_pkg::*;
#(
    parameter logic [31:0] OUT_ADDR        = DEF_OUT_ADDR,
    parameter logic [31:0] IN_ADDR         = DEF_IN_ADDR,
    parameter logic [31:0] STATUS_ADDR     = DEF_STATUS_ADDR,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [31:0] MemReadData,
    input  logic [7:0]  gpio_in,
    output logic [31:0] ReadData,
    output logic        MemWriteOut,
    output logic [7:0]  gpio_out,
    output logic        change_irq
);

    logic       hitOut;
    logic       hitIn;
    logic       hitStatus;
    logic       hit;
    logic [7:0] inDb;
    logic       dbChanged;
    logic       flag;
    logic       unusedWdata;

    assign hitOut    = (Address == OUT_ADDR);
    assign hitIn     = (Address == IN_ADDR);
    assign hitStatus = (Address == STATUS_ADDR);
    assign hit       = hitOut | hitIn | hitStatus;

    assign MemWriteOut = MemWrite & ~hit;
    assign change_irq  = flag;
    assign unusedWdata = &{1'b0, WriteData[31:8]};

    gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (gpio_in),
        .db     (inDb),
        .changed(dbChanged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out <= 8'h00;
            flag     <= 1'b0;
        end else begin
            if (MemWrite && hitOut) begin
                gpio_out <= WriteData[7:0];
            end
            // Set has priority so a change landing on a clear is never lost.
            if (dbChanged) begin
                flag <= 1'b1;
            end else if (MemWrite && hitStatus && WriteData[0]) begin
                flag <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = MemReadData;
        if (hitOut) begin
            ReadData = {24'h0, gpio_out};
        end else if (hitIn) begin
            ReadData = {24'h0, inDb};
        end else if (hitStatus) begin
            ReadData = {31'h0, flag};
        end
    end

endmodule

// File: tb/tb_gpio_mmio_bridge.sv
// tb/tb_gpio_mmio_bridge.sv - scoreboard bench for gpio_mmio_bridge
module tb_gpio_mmio_bridge;

    localparam int          D      = 4;
    localparam logic [31:0] OUT_A  = 32'h1001_0024;
    localparam logic [31:0] IN_A   = 32'h1001_0028;
    localparam logic [31:0] ST_A   = 32'h1001_002C;
    localparam logic [31:0] MISC_A = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] MemReadData;
    logic [7:0]  gpio_in;
    logic [31:0] ReadData;
    logic        MemWriteOut;
    logic [7:0]  gpio_out;
    logic        change_irq;

    always #5 clk = ~clk;

    gpio_mmio_bridge #(
        .OUT_ADDR       (OUT_A),
        .IN_ADDR        (IN_A),
        .STATUS_ADDR    (ST_A),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemReadData(MemReadData),
        .gpio_in    (gpio_in),
        .ReadData   (ReadData),
        .MemWriteOut(MemWriteOut),
        .gpio_out   (gpio_out),
        .change_irq (change_irq)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mwo;
        logic [7:0]  gout;
        logic        irq;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   nChecks = 0;
    int   nFails  = 0;
    int   cycNo   = 0;

    // Reference model: pins reach the debouncer two edges late; a value is
    // accepted once it has differed from the debounced byte on D+1
    // consecutive edges.
    logic [7:0] mOut;
    logic [7:0] mDb;
    logic       mFlag;
    logic [7:0] mPipe[$];
    int         mRun;

    task automatic modelReset();
        mOut  = 8'h00;
        mDb   = 8'h00;
        mFlag = 1'b0;
        mPipe = '{8'h00, 8'h00};
        mRun  = 0;
    endtask

    task automatic modelEdge();
        logic [7:0] seen;
        logic       load;
        if (!reset) return;
        seen = mPipe.pop_front();
        mPipe.push_back(gpio_in);
        load = 1'b0;
        if (seen != mDb) begin
            mRun = mRun + 1;
            if (mRun == D + 1) load = 1'b1;
        end else begin
            mRun = 0;
        end
        if (MemWrite && Address == OUT_A) mOut = WriteData[7:0];
        if (load) begin
            mDb   = seen;
            mRun  = 0;
            mFlag = 1'b1;
        end else if (MemWrite && Address == ST_A && WriteData[0]) begin
            mFlag = 1'b0;
        end
    endtask

    function automatic exp_t expectNow();
        exp_t e;
        logic isGpio;
        isGpio = (Address == OUT_A) || (Address == IN_A) || (Address == ST_A);
        if (Address == OUT_A)     e.rd = {24'h0, mOut};
        else if (Address == IN_A) e.rd = {24'h0, mDb};
        else if (Address == ST_A) e.rd = {31'h0, mFlag};
        else                      e.rd = MemReadData;
        e.mwo  = MemWrite && !isGpio;
        e.gout = mOut;
        e.irq  = mFlag;
        e.cyc  = cycNo;
        return e;
    endfunction

    task automatic cycle(input logic rstv, input logic [31:0] a, input logic [31:0] wd,
                         input logic mw, input logic [31:0] mrd, input logic [7:0] gin);
        @(posedge clk);
        modelEdge();
        #1;
        cycNo       = cycNo + 1;
        reset       = rstv;
        if (!rstv) modelReset();
        Address     = a;
        WriteData   = wd;
        MemWrite    = mw;
        MemReadData = mrd;
        gpio_in     = gin;
        expQ.push_back(expectNow());
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] expv);
        nChecks = nChecks + 1;
        if (act !== expv) begin
            nFails = nFails + 1;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            check("ReadData",    monE.cyc, ReadData,               monE.rd);
            check("MemWriteOut", monE.cyc, {31'h0, MemWriteOut},   {31'h0, monE.mwo});
            check("gpio_out",    monE.cyc, {24'h0, gpio_out},      {24'h0, monE.gout});
            check("change_irq",  monE.cyc, {31'h0, change_irq},    {31'h0, monE.irq});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  gin;
        logic [31:0] a;
        int          budget;
        reset       = 1'b0;
        Address     = MISC_A;
        WriteData   = 32'h0;
        MemWrite    = 1'b0;
        MemReadData = 32'hDEAD_BEEF;
        gpio_in     = 8'h00;
        modelReset();

        // Reset held, then idle read of a memory address.
        cycle(1'b0, MISC_A, 32'h0, 1'b0, 32'hDEAD_BEEF, 8'h00);
        cycle(1'b0, MISC_A, 32'h0, 1'b0, 32'hDEAD_BEEF, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, MISC_A, 32'h0, 1'b0, 32'hDEAD_BEEF, 8'h00);

        // Output register store, then readback.
        cycle(1'b1, OUT_A, 32'h0000_01A5, 1'b1, 32'hDEAD_BEEF, 8'h00);
        cycle(1'b1, OUT_A, 32'h0, 1'b0, 32'hDEAD_BEEF, 8'h00);
        cycle(1'b1, IN_A, 32'hFF, 1'b1, 32'h1234_5678, 8'h00);

        // Three-cycle glitch must be rejected.
        for (int i = 0; i < 3; i++) cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'h3C);
        for (int i = 0; i < 8; i++) cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'h00);

        // Clean step accepted after the full latency.
        for (int i = 0; i < 9; i++) cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'h3C);

        // Clear arriving on the same edge as a new accept: set wins.
        cycle(1'b1, ST_A, 32'h0, 1'b0, 32'h0, 8'h55);
        for (int i = 0; i < 5; i++) cycle(1'b1, ST_A, 32'h0, 1'b0, 32'h0, 8'h55);
        cycle(1'b1, ST_A, 32'h1, 1'b1, 32'h0, 8'h55);
        cycle(1'b1, ST_A, 32'h0, 1'b1, 32'h0, 8'h55);
        cycle(1'b1, ST_A, 32'hFFFF_FFFF, 1'b1, 32'h0, 8'h55);
        cycle(1'b1, ST_A, 32'h0, 1'b0, 32'h0, 8'h55);

        // Reset mid-count discards the pending change.
        cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'hAA);
        for (int i = 0; i < 3; i++) cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'hAA);
        cycle(1'b0, IN_A, 32'h0, 1'b0, 32'h0, 8'hAA);
        cycle(1'b0, OUT_A, 32'h0, 1'b0, 32'h0, 8'hAA);
        for (int i = 0; i < 9; i++) cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'hAA);

        // Third value while counting keeps the count going.
        cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'h11);
        cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'h11);
        for (int i = 0; i < 8; i++) cycle(1'b1, IN_A, 32'h0, 1'b0, 32'h0, 8'h22);

        // Randomized traffic.
        gin = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) gin = 8'($urandom);
            case ($urandom_range(0, 4))
                0:       a = OUT_A;
                1:       a = IN_A;
                2:       a = ST_A;
                3:       a = MISC_A;
                default: a = $urandom;
            endcase
            cycle(($urandom_range(0, 99) != 0), a, $urandom, 1'($urandom_range(0, 1)),
                  $urandom, gin);
        end

        budget = 10;
        while (expQ.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget = budget - 1;
        end
        if (expQ.size() > 0) begin
            nChecks = nChecks + 1;
            nFails  = nFails + 1;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
